matrix_alu_seq: RTL and testbench
=================================

Name: matrix_alu_seq

Overview:
- Parametrised successor to the fixed 4x4/16-bit matrix ALU.
- Holds two operand matrices (A, B) and one result matrix (C), each N x N elements of W bits, packed row-major with element (0,0) in the MSBs.
- Executes add, sub, mult, scale and transpose sequentially, with a Start/Busy/Done handshake, an explicit operand select and optional saturation.
- Sits between the engine bus controller and the matrix register file.

Parameters:
- N, 4: matrix dimension (N >= 2).
- W, 16: element width in bits.
- SATURATE, 0: 0 = results wrap modulo 2^W; 1 = unsigned saturation to [0, 2^W-1].

Ports:
- Clock  in  1  rising-edge clock.
- ResetN  in  1  asynchronous active-low reset.
- WrEn  in  1  load operand on this edge.
- WrSel  in  1  0 = load A, 1 = load B.
- WrData  in  N*N*W  packed matrix; element (r,c) at bits [(N*N-1-(r*N+c))*W +: W].
- RdEn  in  1  request result read.
- RdData  out  N*N*W  registered copy of C.
- RdValid  out  1  one-cycle pulse, RdData updated.
- Start  in  1  begin operation (single-cycle pulse).
- Opcode  in  3  001 add, 010 sub, 011 mult, 100 scale, 101 trans.
- Scalar  in  W  scale factor, captured at Start.
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle completion pulse.
- Error  out  1  one-cycle pulse with Done on an illegal opcode.

Behaviour:
- Reset (ResetN low, asynchronous):
  - A, B, C, working register R and all counters cleared to 0.
  - RdData = 0; Busy, Done, RdValid, Error = 0.
  - FSM goes to IDLE.
  - Reset during EXEC aborts the operation; C keeps its reset value of 0.
- FSM states:
  - IDLE: on Start, capture Opcode and Scalar, clear R and counters, go to EXEC; Busy = 1 from that edge.
  - EXEC: process one step per cycle.
    - Elementwise ops (add, sub, scale, trans): one element per cycle, index i = 0..N*N-1, row-major.
    - mult: one multiply-accumulate per cycle. Element (r,c) accumulates A(r,k)*B(k,c) for k = 0..N-1; accumulator width 2W+clog2(N).
    - After the last step, go to DONE.
  - DONE (one cycle): copy R to C, pulse Done, drop Busy, go to IDLE.
- Latency, measured from the Start edge to the Done high edge:
  - N*N+1 cycles for elementwise ops.
  - N*N*N+1 cycles for mult.
- Illegal opcode (000, 110, 111): go directly to DONE next cycle, pulse Done and Error together, leave C unchanged.
- Arithmetic is unsigned.
  - add: A+B. sub: A-B. scale: A*Scalar. trans: C(r,c) = A(c,r). mult: A x B.
  - SATURATE = 0: result truncated to the low W bits.
  - SATURATE = 1: overflow clamps to 2^W-1; sub underflow clamps to 0.
  - scale and trans ignore B.
- C changes only in the DONE cycle, so partial results are never visible.
- Loads:
  - WrEn in IDLE writes the operand selected by WrSel on that edge.
  - WrEn while Busy is ignored; operands are frozen during EXEC.
- Reads:
  - RdEn registers C into RdData on that edge and pulses RdValid the same edge.
  - Allowed while Busy; returns the previous C.
  - RdData holds its value when RdEn is low (no tri-state).
  - RdEn in the DONE cycle returns the old C; new C is visible from the next read.
- Simultaneous Start and WrEn in IDLE: the write completes first, and the operation uses the new operand.
- Start while Busy is ignored.

Test Plan:
- N=4, W=16. Load A = rows {1,2,3,4}, {5,6,7,8}, {9,10,11,12}, {13,14,15,16}; B = all 1s. add -> C = A+1, Done exactly 17 cycles after Start. Read back -> RdValid pulse, RdData matches.
- mult with A as above and B = identity -> C = A, Done at cycle 65. Then B = A -> C row 0 = {90,100,110,120}.
- SATURATE=1: A = all 0xFFF0, B = all 0x0020. add -> all 0xFFFF. sub B-first case (A = 0x0010, B = 0x0020) -> all 0x0000. SATURATE=0 same add -> all 0x0010.
- scale with Scalar = 3 on the A above -> C(3,3) = 48. trans -> C(0,1) = 5, C(1,0) = 2. Start pulse mid-op ignored, and WrEn during Busy leaves A unchanged.
- Opcode 111 -> Done and Error high together 2 cycles after Start, C unchanged. ResetN low for 1 cycle during a mult -> Busy=0 and C=0 immediately, FSM in IDLE.
- N=3, W=8 instance: add 0xF0+0x20 wraps to 0x10, latency 10 cycles. Packed width 72 bits.

Source files
------------

// File: rtl/matrix_alu_seq.sv
// matrix_alu_seq: sequential N x N matrix ALU (add, sub, mult, scale, trans).
// Operands A and B are loaded whole. Start runs one operation, one element
// (or one multiply-accumulate) per cycle, into a working matrix R. R is
// copied to the result matrix C only in the DONE cycle, so a read never
// returns a partial result.
// Ports:
//   Clock, ResetN        rising-edge clock, asynchronous active-low reset
//   WrEn, WrSel, WrData  load A (WrSel=0) or B (WrSel=1) while idle
//   RdEn, RdData, RdValid  registered read of C, RdValid pulses with the update
//   Start, Opcode, Scalar  begin an operation; Opcode and Scalar captured at Start
//   Busy, Done, Error    status; Done pulses at completion, Error with it on a bad opcode
// Matrices are packed row-major, element (r,c) at [(N*N-1-(r*N+c))*W +: W].
module matrix_alu_seq #(
  parameter int N        = 4,
  parameter int W        = 16,
  parameter int SATURATE = 0
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             WrEn,
  input  logic             WrSel,
  input  logic [N*N*W-1:0] WrData,
  input  logic             RdEn,
  output logic [N*N*W-1:0] RdData,
  output logic             RdValid,
  input  logic             Start,
  input  logic [2:0]       Opcode,
  input  logic [W-1:0]     Scalar,
  output logic             Busy,
  output logic             Done,
  output logic             Error
);

  localparam int NN = N * N;
  localparam int MW = NN * W;
  localparam int CW = $clog2(N);
  localparam int PW = $clog2(MW);
  // Accumulator holds a full N-term sum of W x W products without overflow.
  localparam int AW = 2 * W + $clog2(N);

  typedef enum logic [2:0] {
    OP_ADD   = 3'b001,
    OP_SUB   = 3'b010,
    OP_MULT  = 3'b011,
    OP_SCALE = 3'b100,
    OP_TRANS = 3'b101
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;

  state_e          state, state_next;
  logic [MW-1:0]   a_reg, b_reg, c_reg, r_reg;
  logic [2:0]      op_reg;
  logic [W-1:0]    scalar_reg;
  logic [CW-1:0]   row, col, k;
  logic [AW-1:0]   acc, acc_sum;
  logic [W-1:0]    a_rc, b_rc, a_cr, a_rk, b_kc, elem_res;
  logic [PW-1:0]   wr_base;
  logic            illegal, is_mult, last_k, last_step;
  logic            done_q, error_q, rd_valid_q;
  logic [MW-1:0]   rd_data_q;

  // Bit offset of element (r,c) in a packed matrix.
  function automatic logic [PW-1:0] base_of(input logic [CW-1:0] r,
                                            input logic [CW-1:0] c);
    return PW'((NN - 1 - (int'(r) * N + int'(c))) * W);
  endfunction

  function automatic logic [W-1:0] elem(input logic [MW-1:0] m,
                                        input logic [CW-1:0] r,
                                        input logic [CW-1:0] c);
    return m[base_of(r, c) +: W];
  endfunction

  // Reduce a wide unsigned result to W bits: clamp or wrap.
  function automatic logic [W-1:0] fit(input logic [AW-1:0] v);
    if (SATURATE != 0 && (v >> W) != '0) return '1;
    return v[W-1:0];
  endfunction

  // ---------------------------------------------------------------- datapath
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one
    // unassigned and infers a latch.
    a_rc      = elem(a_reg, row, col);
    b_rc      = elem(b_reg, row, col);
    a_cr      = elem(a_reg, col, row);
    a_rk      = elem(a_reg, row, k);
    b_kc      = elem(b_reg, k, col);
    acc_sum   = acc + AW'(a_rk) * AW'(b_kc);
    wr_base   = base_of(row, col);
    illegal   = !(op_reg inside {OP_ADD, OP_SUB, OP_MULT, OP_SCALE, OP_TRANS});
    is_mult   = (op_reg == OP_MULT);
    last_k    = !is_mult || (k == CW'(N - 1));
    last_step = (row == CW'(N - 1)) && (col == CW'(N - 1)) && last_k;
    elem_res  = '0;
    case (op_reg)
      OP_ADD:   elem_res = fit(AW'(a_rc) + AW'(b_rc));
      OP_SUB:   elem_res = (SATURATE != 0 && a_rc < b_rc) ? '0 : a_rc - b_rc;
      OP_MULT:  elem_res = fit(acc_sum);
      OP_SCALE: elem_res = fit(AW'(a_rc) * AW'(scalar_reg));
      OP_TRANS: elem_res = a_cr;
      default:  elem_res = '0;
    endcase
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (Start) state_next = S_EXEC;
      S_EXEC:  if (illegal || last_step) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      // NOTE: the matrices are plain flops, not RAM, so they can and do
      // take the reset; a reset mid-operation leaves C at zero.
      a_reg      <= '0;
      b_reg      <= '0;
      c_reg      <= '0;
      r_reg      <= '0;
      op_reg     <= '0;
      scalar_reg <= '0;
      row        <= '0;
      col        <= '0;
      k          <= '0;
      acc        <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every right-hand side sees the
      // pre-edge value (e.g. a read in the DONE cycle returns the old C).
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      rd_valid_q <= RdEn;
      if (RdEn) rd_data_q <= c_reg;

      case (state)
        S_IDLE: begin
          if (WrEn) begin
            if (WrSel) b_reg <= WrData;
            else       a_reg <= WrData;
          end
          if (Start) begin
            op_reg     <= Opcode;
            scalar_reg <= Scalar;
            r_reg      <= '0;
            acc        <= '0;
            row        <= '0;
            col        <= '0;
            k          <= '0;
          end
        end
        S_EXEC: begin
          if (!illegal) begin
            if (!last_k) begin
              k   <= k + CW'(1);
              acc <= acc_sum;
            end else begin
              r_reg[wr_base +: W] <= elem_res;
              k   <= '0;
              acc <= '0;
              if (col == CW'(N - 1)) begin
                col <= '0;
                row <= (row == CW'(N - 1)) ? '0 : row + CW'(1);
              end else begin
                col <= col + CW'(1);
              end
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          error_q <= illegal;
          if (!illegal) c_reg <= r_reg;
        end
        default: ;
      endcase
    end
  end

  assign Busy    = (state != S_IDLE);
  assign Done    = done_q;
  assign Error   = error_q;
  assign RdValid = rd_valid_q;
  assign RdData  = rd_data_q;

endmodule

// File: tb/tb_matrix_alu_seq.sv
// Bench for matrix_alu_seq: a transaction-level model of the 4x4/16-bit
// wrapping instance is checked every cycle, plus directed literal checks on
// that instance, a saturating 4x4/16-bit instance and a 3x3/8-bit instance.
module tb_matrix_alu_seq;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MW = N * N * W;

  logic Clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 Clock = ~Clock;

  // instance 0: N=4 W=16 wrapping (model-checked)
  logic wr_en, wr_sel, rd_en, start, rd_valid, busy, done, error;
  logic [MW-1:0] wr_data, rd_data;
  logic [2:0] opcode;
  logic [W-1:0] scalar;
  // instance 1: N=4 W=16 saturating
  logic s_wr_en, s_wr_sel, s_rd_en, s_start, s_rd_valid, s_busy, s_done, s_error;
  logic [MW-1:0] s_wr_data, s_rd_data;
  logic [2:0] s_opcode;
  logic [W-1:0] s_scalar;
  // instance 2: N=3 W=8 wrapping
  logic t_wr_en, t_wr_sel, t_rd_en, t_start, t_rd_valid, t_busy, t_done, t_error;
  logic [71:0] t_wr_data, t_rd_data;
  logic [2:0] t_opcode;
  logic [7:0] t_scalar;

  matrix_alu_seq #(.N(4), .W(16), .SATURATE(0)) u_wrap (
    .Clock(Clock), .ResetN(rst_n), .WrEn(wr_en), .WrSel(wr_sel), .WrData(wr_data),
    .RdEn(rd_en), .RdData(rd_data), .RdValid(rd_valid), .Start(start),
    .Opcode(opcode), .Scalar(scalar), .Busy(busy), .Done(done), .Error(error));

  matrix_alu_seq #(.N(4), .W(16), .SATURATE(1)) u_sat (
    .Clock(Clock), .ResetN(rst_n), .WrEn(s_wr_en), .WrSel(s_wr_sel), .WrData(s_wr_data),
    .RdEn(s_rd_en), .RdData(s_rd_data), .RdValid(s_rd_valid), .Start(s_start),
    .Opcode(s_opcode), .Scalar(s_scalar), .Busy(s_busy), .Done(s_done), .Error(s_error));

  matrix_alu_seq #(.N(3), .W(8), .SATURATE(0)) u_n3 (
    .Clock(Clock), .ResetN(rst_n), .WrEn(t_wr_en), .WrSel(t_wr_sel), .WrData(t_wr_data),
    .RdEn(t_rd_en), .RdData(t_rd_data), .RdValid(t_rd_valid), .Start(t_start),
    .Opcode(t_opcode), .Scalar(t_scalar), .Busy(t_busy), .Done(t_done), .Error(t_error));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ------------------------------------------------------------ matrix helpers
  function automatic longint unsigned get_el(input logic [255:0] m, input int n, input int w,
                                             input int r, input int c);
    logic [255:0] t;
    t = m >> ((n * n - 1 - (r * n + c)) * w);
    return t[63:0] & ((64'd1 << w) - 1);
  endfunction

  function automatic logic [255:0] put_el(input logic [255:0] m, input int n, input int w,
                                          input int r, input int c, input longint unsigned v);
    logic [255:0] t;
    t = 256'(v & ((64'd1 << w) - 1));
    return m | (t << ((n * n - 1 - (r * n + c)) * w));
  endfunction

  function automatic logic [255:0] fill(input longint unsigned v, input int n, input int w);
    logic [255:0] m = '0;
    for (int r = 0; r < n; r++) for (int c = 0; c < n; c++) m = put_el(m, n, w, r, c, v);
    return m;
  endfunction

  // element (r,c) = r*n + c + 1
  function automatic logic [255:0] seq_mat(input int n, input int w);
    logic [255:0] m = '0;
    for (int r = 0; r < n; r++) for (int c = 0; c < n; c++) m = put_el(m, n, w, r, c, r * n + c + 1);
    return m;
  endfunction

  function automatic logic [255:0] ident(input int n, input int w);
    logic [255:0] m = '0;
    for (int r = 0; r < n; r++) m = put_el(m, n, w, r, r, 1);
    return m;
  endfunction

  function automatic logic [255:0] rand_mat(input longint unsigned mask);
    logic [255:0] m = '0;
    for (int r = 0; r < N; r++) for (int c = 0; c < N; c++) m = put_el(m, N, W, r, c, $urandom & mask);
    return m;
  endfunction

  // Reference result of one operation, straight from the arithmetic rules.
  function automatic logic [255:0] model_op(input logic [2:0] op, input logic [255:0] pa,
                                            input logic [255:0] pb, input longint unsigned s,
                                            input int n, input int w, input int sat);
    longint unsigned mask, v, x, y;
    logic [255:0] res = '0;
    mask = (64'd1 << w) - 1;
    for (int r = 0; r < n; r++) begin
      for (int c = 0; c < n; c++) begin
        x = get_el(pa, n, w, r, c);
        y = get_el(pb, n, w, r, c);
        case (op)
          3'd1: v = x + y;
          3'd2: v = (x >= y) ? x - y : ((sat != 0) ? 0 : (x - y) & mask);
          3'd3: begin
            v = 0;
            for (int kk = 0; kk < n; kk++) v += get_el(pa, n, w, r, kk) * get_el(pb, n, w, kk, c);
          end
          3'd4: v = x * s;
          3'd5: v = get_el(pa, n, w, c, r);
          default: v = 0;
        endcase
        if (sat != 0 && v > mask) v = mask;
        res = put_el(res, n, w, r, c, v & mask);
      end
    end
    return res;
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input int n);
    if (!(op inside {[3'd1:3'd5]})) return 2;
    return (op == 3'd3) ? n * n * n + 1 : n * n + 1;
  endfunction

  // ------------------------------------------------------------ model of instance 0
  logic [MW-1:0] ma, mb, mc, m_pend, m_rd;
  logic m_busy, m_done, m_err, m_rdv, m_legal;
  int   m_cnt;

  always @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '0; mb <= '0; mc <= '0; m_pend <= '0; m_rd <= '0;
      m_busy <= 1'b0; m_done <= 1'b0; m_err <= 1'b0; m_rdv <= 1'b0; m_legal <= 1'b0;
      m_cnt <= 0;
    end else begin
      m_rdv  <= rd_en;
      if (rd_en) m_rd <= mc;
      m_done <= 1'b0;
      m_err  <= 1'b0;
      if (!m_busy) begin
        if (wr_en) begin
          if (wr_sel) mb <= wr_data;
          else        ma <= wr_data;
        end
        if (start) begin
          m_busy  <= 1'b1;
          m_legal <= opcode inside {[3'd1:3'd5]};
          m_cnt   <= exp_lat(opcode, N) - 1;
          m_pend  <= model_op(opcode, (wr_en && !wr_sel) ? wr_data : ma,
                              (wr_en && wr_sel) ? wr_data : mb, scalar, N, W, 0);
        end
      end else if (m_cnt == 0) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_err  <= !m_legal;
        if (m_legal) mc <= m_pend;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  always @(negedge Clock) begin
    if (rst_n) begin
      check("cmp busy", busy, m_busy);
      check("cmp done", done, m_done);
      check("cmp error", error, m_err);
      check("cmp rd_valid", rd_valid, m_rdv);
      if (m_rdv) check("cmp rd_data", rd_data, m_rd);
    end
  end

  // ------------------------------------------------------------ drive helpers
  task automatic set_start(input int i, input logic s, input logic [2:0] op, input logic [W-1:0] sc);
    case (i)
      0: begin start = s; opcode = op; scalar = sc; end
      1: begin s_start = s; s_opcode = op; s_scalar = sc; end
      default: begin t_start = s; t_opcode = op; t_scalar = sc[7:0]; end
    endcase
  endtask

  task automatic set_wr(input int i, input logic en, input logic sel, input logic [255:0] d);
    case (i)
      0: begin wr_en = en; wr_sel = sel; wr_data = d[MW-1:0]; end
      1: begin s_wr_en = en; s_wr_sel = sel; s_wr_data = d[MW-1:0]; end
      default: begin t_wr_en = en; t_wr_sel = sel; t_wr_data = d[71:0]; end
    endcase
  endtask

  task automatic set_rd(input int i, input logic en);
    case (i)
      0: rd_en = en;
      1: s_rd_en = en;
      default: t_rd_en = en;
    endcase
  endtask

  function automatic logic get_done(input int i);
    return (i == 0) ? done : (i == 1) ? s_done : t_done;
  endfunction

  function automatic logic get_err(input int i);
    return (i == 0) ? error : (i == 1) ? s_error : t_error;
  endfunction

  task automatic load(input int i, input logic sel, input logic [255:0] d);
    @(negedge Clock);
    set_wr(i, 1'b1, sel, d);
    @(negedge Clock);
    set_wr(i, 1'b0, 1'b0, '0);
  endtask

  // mode 0: quiet; 1: Start + WrEn poke mid-operation; 2: random noise while busy.
  task automatic run_op(input int i, input logic [2:0] op, input logic [W-1:0] sc, input int mode,
                        output int lat, output logic err);
    @(negedge Clock);
    set_start(i, 1'b1, op, sc);
    lat = 0;
    err = 1'b0;
    forever begin
      @(posedge Clock);
      #1;
      if (lat == 0) set_start(i, 1'b0, op, sc);
      if (get_done(i)) begin
        err = get_err(i);
        break;
      end
      lat++;
      if (lat > 200) begin
        n_checks++;
        n_errors++;
        $display("FAIL done timeout: got no Done expected within 200 cycles");
        break;
      end
      if (i == 0 && mode == 1) begin
        if (lat == 5) begin
          set_start(0, 1'b1, 3'd3, '0);
          set_wr(0, 1'b1, 1'b0, '0);
        end else begin
          set_start(0, 1'b0, 3'd3, '0);
          set_wr(0, 1'b0, 1'b0, '0);
        end
      end
      if (i == 0 && mode == 2) begin
        start   = ($urandom_range(0, 3) == 0);
        opcode  = 3'($urandom_range(0, 7));
        wr_en   = $urandom_range(0, 1) == 1;
        wr_sel  = $urandom_range(0, 1) == 1;
        wr_data = {8{$urandom}};
        rd_en   = $urandom_range(0, 1) == 1;
      end
    end
    if (i == 0) begin
      start = 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
    end
  endtask

  task automatic read_c(input int i, output logic [255:0] d, output logic v);
    @(negedge Clock);
    set_rd(i, 1'b1);
    @(posedge Clock);
    #1;
    set_rd(i, 1'b0);
    d = (i == 0) ? rd_data : (i == 1) ? s_rd_data : 256'(t_rd_data);
    v = (i == 0) ? rd_valid : (i == 1) ? s_rd_valid : t_rd_valid;
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    logic [255:0] d, a_cur, b_cur, c_cur, exp;
    logic v, err;
    logic [2:0] op;
    logic [W-1:0] sc;
    longint unsigned mask;
    int lat;

    for (int i = 0; i < 3; i++) begin
      set_start(i, 1'b0, '0, '0);
      set_wr(i, 1'b0, 1'b0, '0);
      set_rd(i, 1'b0);
    end
    rst_n = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check("reset busy", busy, 1'b0);
    check("reset rd_data", rd_data, '0);
    check("reset done", done, 1'b0);
    rst_n = 1'b1;

    // ---- wrapping 4x4: add A + ones
    load(0, 1'b0, seq_mat(N, W));
    load(0, 1'b1, fill(1, N, W));
    run_op(0, 3'd1, '0, 0, lat, err);
    check("add latency", lat, 17);
    check("add error", err, 1'b0);
    read_c(0, d, v);
    check("add rd_valid", v, 1'b1);
    check("add c00", get_el(d, N, W, 0, 0), 2);
    check("add c33", get_el(d, N, W, 3, 3), 17);
    check("add all", d, model_op(3'd1, seq_mat(N, W), fill(1, N, W), 0, N, W, 0));

    // ---- mult by identity, then by A
    load(0, 1'b1, ident(N, W));
    run_op(0, 3'd3, '0, 0, lat, err);
    check("mult latency", lat, 65);
    read_c(0, d, v);
    check("mult ident", d, seq_mat(N, W));
    load(0, 1'b1, seq_mat(N, W));
    run_op(0, 3'd3, '0, 0, lat, err);
    read_c(0, d, v);
    check("mult c00", get_el(d, N, W, 0, 0), 90);
    check("mult c01", get_el(d, N, W, 0, 1), 100);
    check("mult c02", get_el(d, N, W, 0, 2), 110);
    check("mult c03", get_el(d, N, W, 0, 3), 120);

    // ---- scale, transpose
    run_op(0, 3'd4, 16'd3, 0, lat, err);
    read_c(0, d, v);
    check("scale c33", get_el(d, N, W, 3, 3), 48);
    run_op(0, 3'd5, '0, 0, lat, err);
    read_c(0, d, v);
    check("trans c01", get_el(d, N, W, 0, 1), 5);
    check("trans c10", get_el(d, N, W, 1, 0), 2);

    // ---- Start and WrEn while busy are ignored (B currently equals A)
    run_op(0, 3'd1, '0, 1, lat, err);
    check("poke latency", lat, 17);
    read_c(0, d, v);
    check("poke c00", get_el(d, N, W, 0, 0), 2);
    check("poke c33", get_el(d, N, W, 3, 3), 32);

    // ---- wrapping add, then illegal opcode leaves C
    load(0, 1'b0, fill(16'hFFF0, N, W));
    load(0, 1'b1, fill(16'h0020, N, W));
    run_op(0, 3'd1, '0, 0, lat, err);
    read_c(0, d, v);
    check("wrap add", d, fill(16'h0010, N, W));
    run_op(0, 3'd7, '0, 0, lat, err);
    check("illegal latency", lat, 2);
    check("illegal error", err, 1'b1);
    read_c(0, d, v);
    check("illegal keeps c", d, fill(16'h0010, N, W));
    c_cur = fill(16'h0010, N, W);

    // ---- saturating instance
    load(1, 1'b0, fill(16'hFFF0, N, W));
    load(1, 1'b1, fill(16'h0020, N, W));
    run_op(1, 3'd1, '0, 0, lat, err);
    check("sat add latency", lat, 17);
    read_c(1, d, v);
    check("sat add", d, fill(16'hFFFF, N, W));
    run_op(1, 3'd3, '0, 0, lat, err);
    read_c(1, d, v);
    check("sat mult", d, fill(16'hFFFF, N, W));
    load(1, 1'b0, fill(16'h0010, N, W));
    run_op(1, 3'd2, '0, 0, lat, err);
    read_c(1, d, v);
    check("sat sub", d, fill(0, N, W));
    run_op(1, 3'd4, 16'd4096, 0, lat, err);
    read_c(1, d, v);
    check("sat scale", d, model_op(3'd4, fill(16'h0010, N, W), '0, 4096, N, W, 1));

    // ---- 3x3 / 8-bit instance
    load(2, 1'b0, fill(8'hF0, 3, 8));
    load(2, 1'b1, fill(8'h20, 3, 8));
    run_op(2, 3'd1, '0, 0, lat, err);
    check("n3 add latency", lat, 10);
    read_c(2, d, v);
    check("n3 add wrap", d, fill(8'h10, 3, 8));
    load(2, 1'b0, seq_mat(3, 8));
    load(2, 1'b1, ident(3, 8));
    run_op(2, 3'd3, '0, 0, lat, err);
    check("n3 mult latency", lat, 28);
    read_c(2, d, v);
    check("n3 mult ident", d, seq_mat(3, 8));

    // ---- randomized operations on instance 0 with bus noise while busy
    for (int it = 0; it < 25; it++) begin
      case ($urandom_range(0, 2))
        0: mask = 64'hF;
        1: mask = 64'hFF;
        default: mask = 64'hFFFF;
      endcase
      a_cur = rand_mat(mask);
      b_cur = rand_mat(mask);
      load(0, 1'b0, a_cur);
      load(0, 1'b1, b_cur);
      op = 3'($urandom_range(0, 7));
      sc = 16'($urandom);
      run_op(0, op, sc, 2, lat, err);
      check("rand latency", lat, exp_lat(op, N));
      check("rand error", err, !(op inside {[3'd1:3'd5]}));
      exp = (op inside {[3'd1:3'd5]}) ? model_op(op, a_cur, b_cur, sc, N, W, 0) : c_cur;
      read_c(0, d, v);
      check("rand result", d, exp);
      c_cur = exp;
    end

    // ---- reset in the middle of a mult
    load(0, 1'b0, seq_mat(N, W));
    load(0, 1'b1, seq_mat(N, W));
    @(negedge Clock);
    start = 1'b1;
    opcode = 3'd3;
    @(posedge Clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge Clock);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 1'b0);
    check("abort rd_data", rd_data, '0);
    @(posedge Clock);
    #1;
    rst_n = 1'b1;
    read_c(0, d, v);
    check("abort c", d, '0);
    run_op(0, 3'd1, '0, 0, lat, err);
    check("after abort latency", lat, 17);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
